// File: rtl/rs232_tap_pkg.sv
// rs232_tap_pkg
// Shared types and constants for the passive RS232 tap receiver and the
// tick generator it shares with the transmitter side.
// Contents:
//   rx_state_t - receiver FSM state encoding
//   DATA_BITS  - payload bits per 8N1 frame
//   TS_WIDTH   - width of the optional capture timestamp
//   calc_div   - clocks per oversample tick, rounded to nearest
package rs232_tap_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int TS_WIDTH  = 32;

  // Rounded divide so that e.g. 50 MHz / (115200*16) gives 27, not 27.13 -> 27
  // by truncation only by luck.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/rs232_tap_tickgen.sv
// rs232_tap_tickgen
// Oversample tick generator: a counter running 0..DIV-1 that pulses tick for
// one clock when it reaches DIV-1. The clear input holds the counter at 0 so
// the first tick after release lands exactly DIV clocks later.
// Ports:
//   CLOCK_50 - clock
//   RESET    - synchronous active-high reset
//   clear    - hold counter at zero
//   tick     - one-clock pulse every DIV clocks while not cleared
module rs232_tap_tickgen #(
  parameter int DIV = 27
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  // The divider counter. Clear takes priority over the wrap so a receiver
  // sitting in IDLE always restarts its bit timing from a known phase.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || clear) begin
      count <= '0;
    end else if (count == CNT_W'(DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CNT_W'(DIV - 1));

endmodule

// File: rtl/rs232_tap_receiver.sv
// rs232_tap_receiver
// Passive 8N1 deframer for one direction of the RS232 passthrough. Samples
// the tapped line, recovers bytes with framing/overrun status and hands them
// to a logger through a one-entry valid/ready holding register. Never drives
// the line.
// Optional feature: define RS232_TAP_TIMESTAMP_EN to add RX_TIMESTAMP, the
// value of a free-running clock counter captured at each start edge.
// Ports:
//   CLOCK_50     - sole clock
//   RESET        - synchronous active-high reset
//   LINE_IN      - tapped serial line, idle high, asynchronous
//   RX_DATA      - received byte (LSB first on the wire)
//   RX_VALID     - RX_DATA / RX_FRAME_ERR hold a byte
//   RX_READY     - consumer takes the byte when RX_VALID && RX_READY
//   RX_FRAME_ERR - stop bit of this byte was sampled low
//   OVERRUN      - sticky, a byte was dropped because the holder was full
//   OVERRUN_CLR  - clears OVERRUN (a simultaneous new overrun wins)
//   BUSY         - receiver FSM is not IDLE
//   RX_TIMESTAMP - (RS232_TAP_TIMESTAMP_EN only) start-edge clock count
module rs232_tap_receiver
  import rs232_tap_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 LINE_IN,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 RX_FRAME_ERR,
  output logic                 OVERRUN,
  input  logic                 OVERRUN_CLR,
  output logic                 BUSY
`ifdef RS232_TAP_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]  RX_TIMESTAMP
`endif
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam logic [TC_W-1:0] TC_HALF = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
  localparam logic [2:0]      BI_LAST = 3'(DATA_BITS - 1);

  logic sync1;
  logic rx_s;

  rx_state_t state_q, state_d;
  logic [TC_W-1:0]      tc_q, tc_d;
  logic [2:0]           bi_q, bi_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 load_req;
  logic                 tick;

  // Two-flop synchronizer. Both flops reset high so a reset never looks like
  // a start edge on its own; a line that really is low still shows up two
  // clocks later and is treated as a fresh start bit.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= LINE_IN;
      rx_s  <= sync1;
    end
  end

  // Tick timing is only meaningful once a frame has started, so the divider
  // is parked while idle and restarts in phase with the detected start edge.
  rs232_tap_tickgen #(
    .DIV (DIV)
  ) u_tickgen (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .clear    (state_q == IDLE),
    .tick     (tick)
  );

  // FSM state and per-frame counters. A reset mid-frame simply throws away
  // whatever partial byte was collected.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      tc_q    <= '0;
      bi_q    <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      bi_q    <= bi_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic. Every decision happens on a tick: the start bit is
  // re-checked half a bit in, then each data bit and the stop bit are
  // sampled a full bit apart so sampling stays near bit centres. A low stop
  // bit (break) parks in WAIT_HIGH so a held-low line yields a single byte.
  always_comb begin
    state_d  = state_q;
    tc_d     = tc_q;
    bi_d     = bi_q;
    shreg_d  = shreg_q;
    load_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tc_d    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tc_q == TC_HALF) begin
            tc_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bi_d    = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tc_d = tc_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tc_q == TC_LAST) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            tc_d    = '0;
            bi_d    = bi_q + 1'b1;
            if (bi_q == BI_LAST) begin
              state_d = STOP;
            end
          end else begin
            tc_d = tc_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tc_q == TC_LAST) begin
            load_req = 1'b1;
            tc_d     = '0;
            state_d  = rx_s ? IDLE : WAIT_HIGH;
          end else begin
            tc_d = tc_q + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSY = (state_q != IDLE);

`ifdef RS232_TAP_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_count;
  logic [TS_WIDTH-1:0] ts_cap;

  // Free-running clock counter, sampled on the IDLE->START clock. A rejected
  // glitch never reaches STOP, so its stale capture is never delivered and
  // is overwritten by the next start edge.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      ts_count <= '0;
      ts_cap   <= '0;
    end else begin
      ts_count <= ts_count + 1'b1;
      if (state_q == IDLE && !rx_s) begin
        ts_cap <= ts_count;
      end
    end
  end
`endif

  // One-entry holding register. A finished byte is loaded when the holder is
  // empty or being emptied on this same clock; otherwise it is dropped and
  // the overrun flag latched. A new overrun beats a simultaneous clear so a
  // drop is never silently lost.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      RX_VALID     <= 1'b0;
      RX_DATA      <= '0;
      RX_FRAME_ERR <= 1'b0;
      OVERRUN      <= 1'b0;
`ifdef RS232_TAP_TIMESTAMP_EN
      RX_TIMESTAMP <= '0;
`endif
    end else begin
      if (load_req && (!RX_VALID || RX_READY)) begin
        RX_VALID     <= 1'b1;
        RX_DATA      <= shreg_q;
        RX_FRAME_ERR <= !rx_s;
`ifdef RS232_TAP_TIMESTAMP_EN
        RX_TIMESTAMP <= ts_cap;
`endif
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
      if (load_req && RX_VALID && !RX_READY) begin
        OVERRUN <= 1'b1;
      end else if (OVERRUN_CLR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs232_tap_receiver.sv
// tb_rs232_tap_receiver
// Directed bench for rs232_tap_receiver at 50 MHz / 115200 baud, which is
// exactly 432 clocks per bit with the default 27-clock tick and 16x
// oversampling. Serial frames are built bit by bit on LINE_IN; a small
// monitor records every accepted byte so each scenario can compare what was
// delivered against hand-computed values.
module tb_rs232_tap_receiver;

  localparam int BIT_CLKS = 432;

  logic       CLOCK_50;
  logic       RESET;
  logic       LINE_IN;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       RX_FRAME_ERR;
  logic       OVERRUN;
  logic       OVERRUN_CLR;
  logic       BUSY;
`ifdef RS232_TAP_TIMESTAMP_EN
  logic [31:0] RX_TIMESTAMP;
`endif

  int n_compared = 0;
  int n_mismatch = 0;

  int         accept_count = 0;
  int         valid_hi_cycles = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;

  rs232_tap_receiver dut (
    .CLOCK_50     (CLOCK_50),
    .RESET        (RESET),
    .LINE_IN      (LINE_IN),
    .RX_DATA      (RX_DATA),
    .RX_VALID     (RX_VALID),
    .RX_READY     (RX_READY),
    .RX_FRAME_ERR (RX_FRAME_ERR),
    .OVERRUN      (OVERRUN),
    .OVERRUN_CLR  (OVERRUN_CLR),
    .BUSY         (BUSY)
`ifdef RS232_TAP_TIMESTAMP_EN
    ,
    .RX_TIMESTAMP (RX_TIMESTAMP)
`endif
  );

  // 50 MHz clock.
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Handshake monitor, sampling just after each falling edge so inputs
  // driven on that edge have settled.
  always begin
    @(negedge CLOCK_50);
    #1;
    if (RX_VALID) valid_hi_cycles++;
    if (RX_VALID && RX_READY) begin
      accept_count++;
      last_data = RX_DATA;
      last_ferr = RX_FRAME_ERR;
    end
  end

  // Hold the line at one level for a full bit time.
  task automatic drive_bit(input logic b);
    LINE_IN = b;
    repeat (BIT_CLKS) @(negedge CLOCK_50);
  endtask

  // Start bit, eight data bits LSB first, then one stop bit at stop_level;
  // the line is left idle high afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop_level);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_level);
    LINE_IN = 1'b1;
  endtask

  task automatic test_reset;
    RESET       = 1'b1;
    LINE_IN     = 1'b1;
    RX_READY    = 1'b1;
    OVERRUN_CLR = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    n_compared++;
    if (RX_VALID !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_valid: got %b expected 0", RX_VALID);
    end
    n_compared++;
    if (RX_DATA !== 8'h00) begin
      n_mismatch++;
      $display("[TB] FAIL reset_data: got %h expected 00", RX_DATA);
    end
    n_compared++;
    if ({RX_FRAME_ERR, OVERRUN, BUSY} !== 3'b000) begin
      n_mismatch++;
      $display("[TB] FAIL reset_flags: got ferr/ovr/busy %b expected 000", {RX_FRAME_ERR, OVERRUN, BUSY});
    end
    RESET = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    n_compared++;
    if (BUSY !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL idle_after_reset: got busy %b expected 0", BUSY);
    end
  endtask

  task automatic test_basic_byte;
    int acc0, vh0;
    acc0 = accept_count;
    vh0  = valid_hi_cycles;
    RX_READY = 1'b1;
    send_frame(8'h55, 1'b1);
    repeat (10) @(negedge CLOCK_50);
    n_compared++;
    if (accept_count - acc0 !== 1) begin
      n_mismatch++;
      $display("[TB] FAIL basic_count: got %0d bytes expected 1", accept_count - acc0);
    end
    n_compared++;
    if (valid_hi_cycles - vh0 !== 1) begin
      n_mismatch++;
      $display("[TB] FAIL basic_pulse: got %0d valid cycles expected 1", valid_hi_cycles - vh0);
    end
    n_compared++;
    if (last_data !== 8'h55 || last_ferr !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL basic_data: got %h/%b expected 55/0", last_data, last_ferr);
    end
    n_compared++;
    if (BUSY !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL basic_busy: got %b expected 0", BUSY);
    end
  endtask

  task automatic test_glitch;
    int acc0, vh0;
    acc0 = accept_count;
    vh0  = valid_hi_cycles;
    LINE_IN = 1'b0;
    repeat (100) @(negedge CLOCK_50);
    LINE_IN = 1'b1;
    n_compared++;
    if (BUSY !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL glitch_start: got busy %b expected 1", BUSY);
    end
    // Start-bit recheck lands 216 clocks after the synchronized edge.
    repeat (140) @(negedge CLOCK_50);
    n_compared++;
    if (BUSY !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL glitch_idle: got busy %b expected 0", BUSY);
    end
    repeat (BIT_CLKS * 10) @(negedge CLOCK_50);
    n_compared++;
    if (accept_count - acc0 !== 0 || valid_hi_cycles - vh0 !== 0) begin
      n_mismatch++;
      $display("[TB] FAIL glitch_nobyte: got %0d bytes expected 0", accept_count - acc0);
    end
  endtask

  task automatic test_break;
    logic [7:0] b;
    int acc0;
    b = 8'hA5;
    acc0 = accept_count;
    RX_READY = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    LINE_IN = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge CLOCK_50);
    n_compared++;
    if (accept_count - acc0 !== 1) begin
      n_mismatch++;
      $display("[TB] FAIL break_count: got %0d bytes expected 1", accept_count - acc0);
    end
    n_compared++;
    if (last_data !== 8'hA5 || last_ferr !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL break_data: got %h/%b expected a5/1", last_data, last_ferr);
    end
    n_compared++;
    if (BUSY !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL break_wait: got busy %b expected 1", BUSY);
    end
    LINE_IN = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge CLOCK_50);
    n_compared++;
    if (accept_count - acc0 !== 1 || BUSY !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL break_release: got %0d bytes busy %b expected 1 bytes busy 0", accept_count - acc0, BUSY);
    end
  endtask

  task automatic test_overrun;
    RX_READY = 1'b0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (10) @(negedge CLOCK_50);
    n_compared++;
    if (RX_VALID !== 1'b1 || RX_DATA !== 8'h12) begin
      n_mismatch++;
      $display("[TB] FAIL overrun_hold: got valid %b data %h expected 1/12", RX_VALID, RX_DATA);
    end
    n_compared++;
    if (OVERRUN !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL overrun_set: got %b expected 1", OVERRUN);
    end
    RX_READY = 1'b1;
    @(negedge CLOCK_50);
    RX_READY = 1'b0;
    n_compared++;
    if (RX_VALID !== 1'b0 || OVERRUN !== 1'b1) begin
      n_mismatch++;
      $display("[TB] FAIL overrun_drain: got valid %b ovr %b expected 0/1", RX_VALID, OVERRUN);
    end
    OVERRUN_CLR = 1'b1;
    @(negedge CLOCK_50);
    OVERRUN_CLR = 1'b0;
    n_compared++;
    if (OVERRUN !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL overrun_clear: got %b expected 0", OVERRUN);
    end
    RX_READY = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int acc0;
    RX_READY = 1'b1;
    // 0xFF: start bit, then data bits 0..3, then halfway into bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (BIT_CLKS / 2) @(negedge CLOCK_50);
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    n_compared++;
    if ({RX_VALID, RX_FRAME_ERR, OVERRUN, BUSY} !== 4'b0000 || RX_DATA !== 8'h00) begin
      n_mismatch++;
      $display("[TB] FAIL midframe_reset: got v/fe/ovr/busy %b data %h expected 0000/00", {RX_VALID, RX_FRAME_ERR, OVERRUN, BUSY}, RX_DATA);
    end
    RESET = 1'b0;
    acc0 = accept_count;
    repeat (6 * BIT_CLKS) @(negedge CLOCK_50);
    n_compared++;
    if (accept_count - acc0 !== 0 || BUSY !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL midframe_discard: got %0d bytes busy %b expected 0/0", accept_count - acc0, BUSY);
    end
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge CLOCK_50);
    n_compared++;
    if (accept_count - acc0 !== 1 || last_data !== 8'h3C || last_ferr !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL midframe_next: got %0d bytes data %h fe %b expected 1/3c/0", accept_count - acc0, last_data, last_ferr);
    end
  endtask

`ifdef RS232_TAP_TIMESTAMP_EN
  task automatic test_timestamp;
    RESET = 1'b1;
    LINE_IN = 1'b1;
    RX_READY = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    // Counter is k after the k-th rising edge past reset; falling low here
    // reaches rx_s after edge 1000, so the IDLE->START clock sees 1000.
    repeat (998) @(negedge CLOCK_50);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge CLOCK_50);
    n_compared++;
    if (RX_TIMESTAMP !== 32'd1000 || last_data !== 8'h5A) begin
      n_mismatch++;
      $display("[TB] FAIL timestamp: got %0d data %h expected 1000/5a", RX_TIMESTAMP, last_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_byte();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_midframe();
`ifdef RS232_TAP_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
